i2s_adc_rx: RTL and testbench

Audio-input receiver for the WM8731 codec ADC path. It recovers stereo PCM frames from the codec's serial ADC stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT), all oversampled in the 50 MHz system clock. Frames are queued in a small FIFO behind a valid/ready port, and the block keeps a peak level for record/trigger logic. It is the capture-side counterpart of the existing DAC playback path and sits beside `audio` under the top level.

---
 rtl/i2s_adc_rx_if.sv | 31 +++
 rtl/i2s_adc_rx.sv | 214 +++++++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_adc_rx_if.sv
// ---------------------------------------------------------------------------
// i2s_adc_rx_if
// Frame stream from the I2S ADC receiver to its consumer.
//   frame_data  [2*DATA_WIDTH-1:0]  {left, right} head frame, two's complement
//   frame_valid                     producer has a frame at the head
//   frame_ready                     consumer can take the head frame
//
// Handshake: a frame transfers on every rising clk edge where frame_valid and
// frame_ready are both high. frame_data is stable while frame_valid is high
// and no transfer has happened. frame_valid never waits on frame_ready.
// The consumer may hold frame_ready high permanently.
// ---------------------------------------------------------------------------
interface i2s_adc_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0] frame_data;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/i2s_adc_rx.sv
// ---------------------------------------------------------------------------
// i2s_adc_rx
// Capture-side receiver for the WM8731 ADC serial stream. The codec's BCLK,
// ADCLRCK and ADCDAT pins are oversampled in the system clock, stereo words
// are framed by an LRCK-driven FSM, and complete frames are queued in a small
// show-ahead FIFO. A peak-level tracker follows every accepted frame.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   enable         capture enable; low holds the framer in SYNC
//   adc_bclk       codec bit clock (asynchronous)
//   adc_lrck       codec ADC LR clock (low = left, high = right)
//   adc_dat        codec serial data, MSB first, I2S one-bit delay
//   frame_if       frame stream (master): frame_data / frame_valid / frame_ready
//   overflow       sticky: a complete frame was dropped because the FIFO was full
//   frame_err      sticky: an LRCK transition arrived before DATA_WIDTH bits
//   peak           running max of the top 8 bits of |sample| over pushed words
//   peak_clr       clears peak on the next edge (wins over a same-cycle push)
//   o_dbg_state    current framer state (0 SYNC, 1 LEFT, 2 RIGHT)
// ---------------------------------------------------------------------------
module i2s_adc_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                adc_bclk,
  input  logic                adc_lrck,
  input  logic                adc_dat,
  i2s_adc_rx_if.master        frame_if,
  output logic                overflow,
  output logic                frame_err,
  output logic [7:0]          peak,
  input  logic                peak_clr,
  output logic [1:0]          o_dbg_state
);

  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_DW  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH + 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // ---------------- synchronizers and bit strobe ----------------
  logic r_bclk_m, r_bclk_s, r_bclk_d;
  logic r_lrck_m, r_lrck_s;
  logic r_dat_m,  r_dat_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_m <= 1'b0; r_bclk_s <= 1'b0; r_bclk_d <= 1'b0;
      r_lrck_m <= 1'b0; r_lrck_s <= 1'b0;
      r_dat_m  <= 1'b0; r_dat_s  <= 1'b0;
    end else begin
      r_bclk_m <= adc_bclk; r_bclk_s <= r_bclk_m; r_bclk_d <= r_bclk_s;
      r_lrck_m <= adc_lrck; r_lrck_s <= r_lrck_m;
      r_dat_m  <= adc_dat;  r_dat_s  <= r_dat_m;
    end
  end

  // LRCK and DAT go through the same two stages as BCLK, so at the strobe
  // they show the pin values present at the BCLK rise.
  logic w_bit_stb, w_edge, w_fall, w_rise, w_cnt_full;
  logic r_lr_prev;
  logic [CW-1:0] r_cnt;

  assign w_bit_stb  = r_bclk_s & ~r_bclk_d;
  assign w_edge     = w_bit_stb && (r_lrck_s != r_lr_prev);
  assign w_fall     = w_edge && !r_lrck_s;
  assign w_rise     = w_edge &&  r_lrck_s;
  assign w_cnt_full = (r_cnt >= CNT_DW);

  // ---------------- framer ----------------
  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [DATA_WIDTH-1:0]   r_left_hold;
  logic                    r_frame_err;

  // The closing 1->0 edge of a good right slot is the push; the FIFO takes it
  // on the same clk edge the FSM leaves RIGHT.
  logic                    w_push;
  logic [2*DATA_WIDTH-1:0] w_push_data;
  assign w_push      = enable && (r_state == ST_RIGHT) && w_fall && w_cnt_full;
  assign w_push_data = {r_left_hold, r_shift};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SYNC;
      r_cnt       <= '0;
      r_lr_prev   <= 1'b1;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_frame_err <= 1'b0;
    end else begin
      // The transition strobe carries the I2S delay bit, so it only zeroes
      // the counter; data bits 1..DATA_WIDTH follow, anything later is padding.
      if (w_bit_stb) begin
        r_lr_prev <= r_lrck_s;
        if (w_edge) begin
          r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt < CNT_DW) r_shift <= {r_shift[DATA_WIDTH-2:0], r_dat_s};
        end
      end

      if (!enable) begin
        r_state <= ST_SYNC;
      end else if (w_edge) begin
        case (r_state)
          ST_SYNC: if (w_fall) r_state <= ST_LEFT;
          ST_LEFT: begin
            if (w_rise) begin
              if (w_cnt_full) begin
                r_left_hold <= r_shift;
                r_state     <= ST_RIGHT;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_SYNC;
              end
            end
          end
          ST_RIGHT: begin
            if (w_fall) begin
              if (w_cnt_full) begin
                r_state <= ST_LEFT;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_SYNC;
              end
            end
          end
          default: r_state <= ST_SYNC;
        endcase
      end
    end
  end

  // ---------------- frame FIFO ----------------
  logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [AW:0]             r_count;
  logic                    r_overflow;
  logic [7:0]              r_peak;
  logic                    w_pop, w_full, w_wr;

  assign w_full = (r_count == FIFO_FULL);
  assign w_pop  = (r_count != '0) && frame_if.frame_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign w_wr   = w_push && (!w_full || w_pop);

  // Saturating magnitude: the most negative word maps to the largest positive.
  function automatic logic [7:0] top_abs(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] a;
    if (w == {1'b1, {(DATA_WIDTH-1){1'b0}}})
      a = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (w[DATA_WIDTH-1])
      a = -w;
    else
      a = w;
    return a[DATA_WIDTH-1 -: 8];
  endfunction

  logic [7:0] w_abs_l, w_abs_r, w_peak_next;
  always_comb begin
    w_abs_l     = top_abs(r_left_hold);
    w_abs_r     = top_abs(r_shift);
    w_peak_next = r_peak;
    if (w_abs_l > w_peak_next) w_peak_next = w_abs_l;
    if (w_abs_r > w_peak_next) w_peak_next = w_abs_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_peak     <= 8'h00;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) r_overflow <= 1'b1;
      if (peak_clr)  r_peak <= 8'h00;
      else if (w_wr) r_peak <= w_peak_next;
    end
  end

  assign frame_if.frame_data  = r_mem[r_rd_ptr];
  assign frame_if.frame_valid = (r_count != '0);
  assign overflow             = r_overflow;
  assign frame_err            = r_frame_err;
  assign peak                 = r_peak;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_adc_rx
// Drives an I2S ADC stream (BCLK = clk/16) slot by slot. A word-level model
// tracks slot lengths and LRCK edges to decide which {left,right} frames must
// come out, plus the FIFO occupancy, sticky flags and peak. One compare
// process checks every popped frame against the expected queue.
// ---------------------------------------------------------------------------
module tb_i2s_adc_rx;
  localparam int DW   = 16;
  localparam int HALF = 8;   // clk cycles per BCLK phase

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic enable, adc_bclk, adc_lrck, adc_dat, peak_clr;
  logic overflow, frame_err;
  logic [7:0] peak;
  logic [1:0] dbg_state;

  i2s_adc_rx_if #(.DATA_WIDTH(DW)) frm_if ();

  i2s_adc_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .adc_bclk   (adc_bclk),
    .adc_lrck   (adc_lrck),
    .adc_dat    (adc_dat),
    .frame_if   (frm_if),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .peak       (peak),
    .peak_clr   (peak_clr),
    .o_dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  int pops;
  int valid_cycles;

  // word-level model
  int          m_phase;      // 0 unsynced, 1 inside a left slot, 2 inside a right slot after a good left
  logic        m_cur_lr;
  int          m_len;        // bits sent in the current slot, delay bit included
  logic [15:0] m_slot_word;
  logic [15:0] m_left;
  logic        m_err, m_ovf;
  logic [7:0]  m_peak;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return 'x;
  endfunction

  function automatic logic [7:0] mag8(input logic [15:0] w);
    int v;
    v = int'($signed(w));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return 8'(v / 256);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pop_log.delete();
    pops = 0;
    valid_cycles = 0;
    m_phase = 0;
    m_cur_lr = 1'b1;
    m_len = 0;
    m_slot_word = '0;
    m_left = '0;
    m_err = 1'b0;
    m_ovf = 1'b0;
    m_peak = 8'h00;
  endtask

  task automatic model_push(input logic [31:0] f);
    logic [7:0] a, b;
    if (exp_q.size() >= 4) begin
      m_ovf = 1'b1;
    end else begin
      exp_q.push_back(f);
      a = mag8(f[31:16]);
      b = mag8(f[15:0]);
      if (a > m_peak) m_peak = a;
      if (b > m_peak) m_peak = b;
    end
  endtask

  // A slot is complete when it held the delay bit plus DW data bits.
  task automatic model_edge(input logic lr);
    if (!enable) begin
      m_phase = 0;
    end else if (!lr) begin
      if (m_phase == 2 && m_len >= DW + 1) begin
        model_push({m_left, m_slot_word});
        m_phase = 1;
      end else if (m_phase == 2) begin
        m_err = 1'b1;
        m_phase = 0;
      end else begin
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_len >= DW + 1) begin
        m_left = m_slot_word;
        m_phase = 2;
      end else begin
        m_err = 1'b1;
        m_phase = 0;
      end
    end
    m_cur_lr = lr;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic lr, input logic d);
    adc_bclk = 1'b0;
    adc_lrck = lr;
    adc_dat  = d;
    tick(HALF);
    adc_bclk = 1'b1;
    tick(HALF);
  endtask

  // Delay bit is driven 1 and padding alternates, so a receiver that shifts
  // either of them in produces a wrong word.
  task automatic send_slot(input logic lr, input logic [15:0] word, input int nbits);
    logic b;
    if (lr != m_cur_lr) begin
      model_edge(lr);
      m_len = 0;
      m_slot_word = word;
    end
    m_len += nbits;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)       b = 1'b1;
      else if (i <= DW) b = word[DW-i];
      else              b = 1'(i % 2);
      send_bit(lr, b);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits);
    send_slot(1'b0, l, nbits);
    send_slot(1'b1, r, nbits);
  endtask

  task automatic do_reset();
    adc_bclk = 1'b0;
    adc_lrck = 1'b1;
    adc_dat  = 1'b0;
    reset = 1'b1;
    tick(4);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_err));
    chk({tag, "_peak"}, 32'(peak), 32'(m_peak));
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (frm_if.frame_valid) valid_cycles++;
      if (frm_if.frame_valid && frm_if.frame_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", frm_if.frame_data, 32'hxxxxxxxx);
        end else begin
          chk("pop_data", frm_if.frame_data, exp_q.pop_front());
        end
        pop_log.push_back(frm_if.frame_data);
        pops++;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    enable = 1'b1;
    peak_clr = 1'b0;
    frm_if.frame_ready = 1'b0;
    reset = 1'b1;
    model_reset();

    // Reset values
    do_reset();
    tick(1);
    chk("rst_valid", 32'(frm_if.frame_valid), 32'd0);
    chk("rst_data", frm_if.frame_data, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_peak", 32'(peak), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Alignment: reset released in the middle of a right slot
    frm_if.frame_ready = 1'b1;
    reset = 1'b1;
    tick(2);
    fork
      begin
        send_slot(1'b0, 16'hDEAD, 32);
        send_slot(1'b1, 16'hBEEF, 32);
        send_frame(16'h0F0F, 16'hF0F0, 17);
        send_slot(1'b0, 16'h0000, 2);
      end
      begin
        tick(32*2*HALF + 16*2*HALF);
        reset = 1'b0;
        model_reset();
      end
    join
    tick(20);
    chk("align_pops", pops, 1);
    chk("align_frame", pop_at(0), 32'h0F0FF0F0);
    check_flags("align");

    // Basic capture, 32 BCLK per slot
    do_reset();
    frm_if.frame_ready = 1'b1;
    send_frame(16'hA5C3, 16'h1234, 32);
    send_frame(16'h8001, 16'h7FFF, 32);
    send_slot(1'b0, 16'h0000, 2);
    tick(20);
    chk("basic_pops", pops, 2);
    chk("basic_valid_cycles", valid_cycles, 2);
    chk("basic_frame0", pop_at(0), 32'hA5C31234);
    chk("basic_frame1", pop_at(1), 32'h80017FFF);
    chk("basic_peak_lit", 32'(peak), 32'h7F);
    check_flags("basic");

    // Overflow: five frames with the consumer stalled
    do_reset();
    frm_if.frame_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_frame(16'(k * 16'h1111), 16'(16'hF000 + k), 17);
    send_frame(16'h0001, 16'h0002, 17);
    send_slot(1'b0, 16'h0000, 2);
    tick(20);
    chk("ovf_valid_full", 32'(frm_if.frame_valid), 32'd1);
    chk("ovf_flag_lit", 32'(overflow), 32'd1);
    check_flags("ovf");
    frm_if.frame_ready = 1'b1;
    tick(10);
    chk("ovf_drain_pops", pops, 4);
    chk("ovf_first", pop_at(0), 32'h1111F001);
    chk("ovf_last", pop_at(3), 32'h4444F004);
    chk("ovf_drained_valid", 32'(frm_if.frame_valid), 32'd0);

    // Short left slot (10 data bits), then recovery
    do_reset();
    frm_if.frame_ready = 1'b1;
    send_slot(1'b0, 16'hFFFF, 11);
    send_slot(1'b1, 16'h1234, 32);
    send_frame(16'h5A5A, 16'hA5A5, 17);
    send_slot(1'b0, 16'h0000, 2);
    tick(20);
    chk("short_err_lit", 32'(frame_err), 32'd1);
    chk("short_pops", pops, 1);
    chk("short_frame", pop_at(0), 32'h5A5AA5A5);
    check_flags("short");

    // Left slot one bit short of a full word
    do_reset();
    frm_if.frame_ready = 1'b1;
    send_slot(1'b0, 16'hFFFF, DW);
    send_slot(1'b1, 16'h0000, 17);
    send_slot(1'b0, 16'h0000, 2);
    tick(20);
    chk("dwm1_err_lit", 32'(frame_err), 32'd1);
    chk("dwm1_pops", pops, 0);

    // Peak tracking and clear
    do_reset();
    frm_if.frame_ready = 1'b1;
    send_frame(16'h8000, 16'h0100, 17);
    send_slot(1'b0, 16'hFF00, 17);
    chk("peak_a_lit", 32'(peak), 32'h7F);
    chk("peak_a_model", 32'(peak), 32'(m_peak));
    peak_clr = 1'b1;
    tick(1);
    peak_clr = 1'b0;
    m_peak = 8'h00;
    chk("peak_clr", 32'(peak), 32'd0);
    send_slot(1'b1, 16'h0000, 17);
    send_slot(1'b0, 16'h0000, 2);
    tick(20);
    chk("peak_b_lit", 32'(peak), 32'h01);
    chk("peak_b_model", 32'(peak), 32'(m_peak));
    chk("peak_frame1", pop_at(1), 32'hFF000000);

    // Reset in the middle of operation
    do_reset();
    frm_if.frame_ready = 1'b0;
    send_slot(1'b0, 16'h0000, 5);
    send_slot(1'b1, 16'h0000, 17);
    send_frame(16'h3000, 16'h0200, 17);
    send_frame(16'h0400, 16'h0500, 17);
    send_frame(16'h0600, 16'h0700, 17);
    send_slot(1'b0, 16'h0800, 17);
    send_slot(1'b1, 16'h0900, 8);
    chk("mid_pre_valid", 32'(frm_if.frame_valid), 32'd1);
    chk("mid_pre_queued", exp_q.size(), 3);
    check_flags("mid_pre");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    chk("mid_post_valid", 32'(frm_if.frame_valid), 32'd0);
    chk("mid_post_overflow", 32'(overflow), 32'd0);
    chk("mid_post_frame_err", 32'(frame_err), 32'd0);
    chk("mid_post_peak", 32'(peak), 32'd0);
    chk("mid_post_state", 32'(dbg_state), 32'd0);
    frm_if.frame_ready = 1'b1;
    send_slot(1'b1, 16'h0000, 9);
    send_frame(16'h1357, 16'h2468, 17);
    send_slot(1'b0, 16'h0000, 2);
    tick(20);
    chk("mid_restart_pops", pops, 1);
    chk("mid_restart_frame", pop_at(0), 32'h13572468);

    // Enable dropped during a frame discards it
    do_reset();
    frm_if.frame_ready = 1'b1;
    send_slot(1'b0, 16'h1111, 17);
    send_slot(1'b1, 16'h2222, 8);
    enable = 1'b0;
    m_phase = 0;
    send_slot(1'b1, 16'h0000, 4);
    enable = 1'b1;
    send_slot(1'b1, 16'h0000, 5);
    send_frame(16'h7777, 16'h8888, 17);
    send_slot(1'b0, 16'h0000, 2);
    tick(20);
    chk("en_pops", pops, 1);
    chk("en_frame", pop_at(0), 32'h77778888);
    chk("en_state_left", 32'(dbg_state), 32'd1);
    check_flags("en");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
